// File: rtl/instr_fetch_cache.sv
// Instruction-fetch front end: direct-mapped one-word-per-line cache with bypass,
// flush, and saturating hit/miss counters, in front of a request/response memory port.
module instr_fetch_cache #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINES      = 16,
  parameter int unsigned CACHE_EN   = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fetch_en_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  instr_valid_o,
  output logic                  busy_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_read_en_o,
  input  logic [31:0]           mem_read_val_i,
  input  logic                  mem_response_i,
  output logic [15:0]           hit_count_o,
  output logic [15:0]           miss_count_o
);

  localparam int unsigned IdxW = $clog2(LINES);

  typedef enum logic {StIdle, StMiss} state_e;

  state_e                state_q;
  logic [LINES-1:0]      valid_q;
  // Whole address kept as the tag; the index bits always match, so this avoids a
  // zero-width tag when LINES == 2**ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] tag_q [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  flush_seen_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_valid_q;
  logic [31:0]           mem_addr_q;
  logic                  mem_read_en_q;
  logic [15:0]           hit_count_q;
  logic [15:0]           miss_count_q;

  logic [IdxW-1:0] idx;
  logic [IdxW-1:0] fill_idx;
  logic            hit;
  logic            install;

  assign idx      = fetch_addr_i[IdxW-1:0];
  assign fill_idx = req_addr_q[IdxW-1:0];
  assign hit      = (CACHE_EN != 0) && valid_q[idx] && (tag_q[idx] == fetch_addr_i);
  // A fill is dropped if a flush landed at any point during its miss.
  assign install  = (state_q == StMiss) && mem_response_i && (CACHE_EN != 0) &&
                    !flush_i && !flush_seen_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      req_addr_q    <= '0;
      flush_seen_q  <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      if (flush_i) valid_q <= '0;
      if (install) valid_q[fill_idx] <= 1'b1;
      unique case (state_q)
        StIdle: begin
          flush_seen_q <= 1'b0;
          if (fetch_en_i) begin
            if (hit) begin
              instr_q       <= data_q[idx];
              instr_valid_q <= 1'b1;
              hit_count_q   <= (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
            end else begin
              req_addr_q    <= fetch_addr_i;
              mem_addr_q    <= 32'(fetch_addr_i);
              mem_read_en_q <= 1'b1;
              miss_count_q  <= (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
              state_q       <= StMiss;
            end
          end
        end
        StMiss: begin
          if (flush_i) flush_seen_q <= 1'b1;
          if (mem_response_i) begin
            instr_q       <= mem_read_val_i[DATA_WIDTH-1:0];
            instr_valid_q <= 1'b1;
            mem_read_en_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (install) begin
      tag_q[fill_idx]  <= req_addr_q;
      data_q[fill_idx] <= mem_read_val_i[DATA_WIDTH-1:0];
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign busy_o        = (state_q == StMiss);
  assign mem_addr_o    = mem_addr_q;
  assign mem_read_en_o = mem_read_en_q;
  assign hit_count_o   = hit_count_q;
  assign miss_count_o  = miss_count_q;

endmodule

// File: tb/tb_instr_fetch_cache.sv
// Scoreboard bench: instance 0 runs with the cache enabled, instance 1 in bypass.
module tb_instr_fetch_cache;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        fetch_en     [2];
  logic [7:0]  fetch_addr   [2];
  logic        flush        [2];
  logic [31:0] instr        [2];
  logic        instr_valid  [2];
  logic        busy         [2];
  logic [31:0] mem_addr     [2];
  logic        mem_read_en  [2];
  logic [31:0] mem_read_val [2];
  logic        mem_response [2];
  logic [15:0] hit_count    [2];
  logic [15:0] miss_count   [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    instr_fetch_cache #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .LINES(16),
      .CACHE_EN((g == 0) ? 1 : 0)
    ) u_dut (
      .clk_i         (clk),
      .reset_i       (reset[g]),
      .fetch_en_i    (fetch_en[g]),
      .fetch_addr_i  (fetch_addr[g]),
      .flush_i       (flush[g]),
      .instr_o       (instr[g]),
      .instr_valid_o (instr_valid[g]),
      .busy_o        (busy[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_read_en_o (mem_read_en[g]),
      .mem_read_val_i(mem_read_val[g]),
      .mem_response_i(mem_response[g]),
      .hit_count_o   (hit_count[g]),
      .miss_count_o  (miss_count[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'h05) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | ({24'h0, a} * 32'h0000_0101);
  endfunction

  task automatic push(input int u, input logic [31:0] v);
    if (u == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  always @(negedge clk) begin
    if (instr_valid[0] === 1'b1) begin
      if (exp_q0.size() == 0) check("spurious_valid0", 32'd1, 32'd0);
      else check("instr0", instr[0], exp_q0.pop_front());
    end
    if (instr_valid[1] === 1'b1) begin
      if (exp_q1.size() == 0) check("spurious_valid1", 32'd1, 32'd0);
      else check("instr1", instr[1], exp_q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while (busy[u] !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic counts(input int u, input int h, input int m);
    check("hit_count", 32'(hit_count[u]), h);
    check("miss_count", 32'(miss_count[u]), m);
  endtask

  // lat = cycles from first busy cycle to the mem_response cycle, inclusive.
  task automatic do_fetch(input int u, input logic [7:0] a, input bit hit, input int lat,
                          input bit flush_mid);
    wait_idle(u);
    fetch_en[u]   = 1'b1;
    fetch_addr[u] = a;
    push(u, mem_word(a));
    tick();
    fetch_en[u] = 1'b0;
    if (hit) begin
      check("hit_valid", instr_valid[u], 1);
      check("hit_no_mem", mem_read_en[u], 0);
      check("hit_busy", busy[u], 0);
    end else begin
      check("miss_busy", busy[u], 1);
      check("miss_rd_en", mem_read_en[u], 1);
      check("miss_addr", mem_addr[u], {24'h0, a});
      if (flush_mid) flush[u] = 1'b1;
      for (int i = 1; i < lat; i++) begin
        tick();
        flush[u] = 1'b0;
        check("miss_hold_rd_en", mem_read_en[u], 1);
        check("miss_hold_addr", mem_addr[u], {24'h0, a});
      end
      mem_response[u] = 1'b1;
      mem_read_val[u] = mem_word(a);
      tick();
      mem_response[u] = 1'b0;
      flush[u]        = 1'b0;
      mem_read_val[u] = $urandom;
      check("fill_valid", instr_valid[u], 1);
      check("fill_busy", busy[u], 0);
      check("fill_rd_en", mem_read_en[u], 0);
      check("fill_addr_hold", mem_addr[u], {24'h0, a});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; fetch_en[u] = 1'b0; fetch_addr[u] = '0; flush[u] = 1'b0;
      mem_read_val[u] = '0; mem_response[u] = 1'b0;
    end
    tick(); tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_instr", instr[u], 0);
      check("rst_valid", instr_valid[u], 0);
      check("rst_busy", busy[u], 0);
      check("rst_mem_addr", mem_addr[u], 0);
      check("rst_rd_en", mem_read_en[u], 0);
      counts(u, 0, 0);
      reset[u] = 1'b0;
    end
    tick();

    // Cold miss then hit.
    do_fetch(0, 8'h05, 0, 3, 0);
    counts(0, 0, 1);
    check("instr_deadbeef", instr[0], 32'hDEADBEEF);
    do_fetch(0, 8'h05, 1, 0, 0);
    counts(0, 1, 1);

    // Conflict eviction, minimum-latency fill included.
    do_fetch(0, 8'h15, 0, 1, 0);
    do_fetch(0, 8'h05, 0, 2, 0);
    counts(0, 1, 3);

    // Back-to-back hits.
    do_fetch(0, 8'h05, 1, 0, 0);
    do_fetch(0, 8'h05, 1, 0, 0);
    counts(0, 3, 3);

    // mem_response while idle must be ignored.
    mem_response[0] = 1'b1;
    mem_read_val[0] = 32'h1234_5678;
    tick();
    mem_response[0] = 1'b0;
    check("idle_resp_valid", instr_valid[0], 0);
    check("idle_resp_instr", instr[0], 32'hDEADBEEF);
    check("idle_resp_busy", busy[0], 0);

    // Flush coinciding with a hit: the hit uses pre-flush contents, then misses.
    flush[0] = 1'b1;
    do_fetch(0, 8'h05, 1, 0, 0);
    flush[0] = 1'b0;
    do_fetch(0, 8'h05, 0, 1, 0);
    counts(0, 4, 4);

    // Flush during a miss (earlier, and in the response cycle): data returned, no install.
    do_fetch(0, 8'h0A, 0, 2, 1);
    do_fetch(0, 8'h0B, 0, 1, 1);
    do_fetch(0, 8'h0A, 0, 1, 0);
    do_fetch(0, 8'h0B, 0, 2, 0);
    do_fetch(0, 8'h0A, 1, 0, 0);
    do_fetch(0, 8'h0B, 1, 0, 0);
    counts(0, 6, 8);

    // Reset during a miss, then a late response.
    wait_idle(0);
    fetch_en[0]   = 1'b1;
    fetch_addr[0] = 8'h09;
    tick();
    fetch_en[0] = 1'b0;
    check("pre_rst_busy", busy[0], 1);
    reset[0] = 1'b1;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_rd_en", mem_read_en[0], 0);
    check("mid_rst_addr", mem_addr[0], 0);
    check("mid_rst_instr", instr[0], 0);
    counts(0, 0, 0);
    tick();
    reset[0]        = 1'b0;
    mem_response[0] = 1'b1;
    mem_read_val[0] = mem_word(8'h09);
    tick();
    mem_response[0] = 1'b0;
    check("late_resp_valid", instr_valid[0], 0);
    check("late_resp_instr", instr[0], 0);
    check("late_resp_busy", busy[0], 0);
    check("late_resp_rd_en", mem_read_en[0], 0);
    do_fetch(0, 8'h09, 0, 2, 0);
    do_fetch(0, 8'h09, 1, 0, 0);
    counts(0, 1, 1);

    // Bypass instance: every fetch goes to memory.
    do_fetch(1, 8'h07, 0, 2, 0);
    do_fetch(1, 8'h07, 0, 1, 0);
    counts(1, 0, 2);

    tick(); tick();
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
